// File: rtl/pe_conv_window_gen_conv1.sv
// Sliding-window generator for the conv1 MAC input buffer: raster pixels in,
// one flattened KxK window out, sequenced element-by-element over K*K beats.
module pe_conv_window_gen_conv1 #(
  parameter int pDATA_WIDTH    = 8,
  parameter int pKERNEL_SIZE   = 3,
  parameter int pINPUT_CHANNEL = 1,
  parameter int pIMG_WIDTH     = 32,
  parameter int pIMG_HEIGHT    = 32
) (
  input  logic                                                             clk,
  input  logic                                                             rst,
  input  logic                                                             in_valid,
  input  logic [pDATA_WIDTH*pINPUT_CHANNEL-1:0]                            in_data,
  output logic                                                             in_ready,
  output logic [pDATA_WIDTH*pINPUT_CHANNEL*pKERNEL_SIZE*pKERNEL_SIZE-1:0] win_data,
  output logic [$clog2(pKERNEL_SIZE*pKERNEL_SIZE)-1:0]                     pixel,
  output logic                                                             en,
  output logic                                                             frame_done
);
  localparam int K      = pKERNEL_SIZE;
  localparam int KK     = K * K;
  localparam int W      = pIMG_WIDTH;
  localparam int H      = pIMG_HEIGHT;
  localparam int DW     = pDATA_WIDTH * pINPUT_CHANNEL;
  localparam int PW     = $clog2(KK);
  localparam int CW     = $clog2(W);
  localparam int RW     = $clog2(H);
  // Past pixels needed so the oldest window tap, (K-1) rows plus (K-1) columns back, is still held.
  localparam int SR_LEN = (K - 1) * W + K - 1;

  typedef enum logic {FILL, SCAN} state_t;

  state_t                   state_q, state_d;
  logic [CW-1:0]            col_q, col_d;
  logic [RW-1:0]            row_q, row_d;
  logic                     last_q, last_d;
  logic                     ready_d, en_d, done_d, load_win;
  logic [PW-1:0]            pixel_d;
  logic                     accept;
  logic [SR_LEN-1:0][DW-1:0] sr;
  logic [KK-1:0][DW-1:0]    win_d;

  assign accept = in_valid & in_ready;

  // Line buffers as one long shift register; sr[0] is the most recent pixel.
  always_ff @(posedge clk) begin
    if (accept) sr <= {sr[SR_LEN-2:0], in_data};
  end

  // Window taps as they will look after the current pixel is shifted in.
  for (genvar p = 0; p < KK; p++) begin : g_tap
    localparam int OFS = (K - 1 - p / K) * W + (K - 1 - p % K);
    if (OFS == 0) begin : g_new
      assign win_d[KK-1-p] = in_data;
    end else begin : g_old
      assign win_d[KK-1-p] = sr[OFS-1];
    end
  end

  always_comb begin
    state_d  = state_q;
    col_d    = col_q;
    row_d    = row_q;
    last_d   = last_q;
    ready_d  = 1'b1;
    en_d     = 1'b0;
    pixel_d  = '0;
    done_d   = 1'b0;
    load_win = 1'b0;
    case (state_q)
      FILL: begin
        if (accept) begin
          if (col_q == CW'(W - 1)) begin
            col_d = '0;
            row_d = (row_q == RW'(H - 1)) ? '0 : row_q + RW'(1);
          end else begin
            col_d = col_q + CW'(1);
          end
          if (row_q >= RW'(K - 1) && col_q >= CW'(K - 1)) begin
            load_win = 1'b1;
            state_d  = SCAN;
            ready_d  = 1'b0;
            en_d     = 1'b1;
            last_d   = (row_q == RW'(H - 1)) && (col_q == CW'(W - 1));
          end
        end
      end
      SCAN: begin
        ready_d = 1'b0;
        en_d    = 1'b1;
        pixel_d = pixel + PW'(1);
        if (pixel == PW'(KK - 1)) begin
          state_d = FILL;
          ready_d = 1'b1;
          en_d    = 1'b0;
          pixel_d = '0;
          done_d  = last_q;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= FILL;
      col_q      <= '0;
      row_q      <= '0;
      last_q     <= 1'b0;
      in_ready   <= 1'b0;
      en         <= 1'b0;
      pixel      <= '0;
      frame_done <= 1'b0;
      win_data   <= '0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      row_q      <= row_d;
      last_q     <= last_d;
      in_ready   <= ready_d;
      en         <= en_d;
      pixel      <= pixel_d;
      frame_done <= done_d;
      if (load_win) win_data <= win_d;
    end
  end
endmodule

// File: doc/pe_conv_window_gen_conv1.md
Name: pe_conv_window_gen_conv1

Overview:
- Producer side of the conv1 MAC input buffer interface.
- Accepts a raster-scanned input feature-map pixel stream over a valid/ready handshake and holds pKERNEL_SIZE-1 line buffers.
- For every complete pKERNEL_SIZE x pKERNEL_SIZE receptive field, presents the flattened window on win_data and sequences en/pixel over pKERNEL_SIZE^2 cycles, so the buffer emits one window element per cycle.
- Stride 1, no padding, one frame at a time.

Parameters:
- pDATA_WIDTH, 8: bits per pixel per channel.
- pKERNEL_SIZE, 3: kernel height and width.
- pINPUT_CHANNEL, 1: channels packed per input beat; must be 1 for conv1.
- pIMG_WIDTH, 32: input frame width in pixels; must be >= pKERNEL_SIZE.
- pIMG_HEIGHT, 32: input frame height in pixels; must be >= pKERNEL_SIZE.

Ports:
- clk, input, 1: clock, all logic on rising edge.
- rst, input, 1: asynchronous active-low reset.
- in_valid, input, 1: in_data valid.
- in_data, input, pDATA_WIDTH*pINPUT_CHANNEL: raster-order pixel.
- in_ready, output, 1: block can accept a pixel.
- win_data, output, pDATA_WIDTH*pINPUT_CHANNEL*pKERNEL_SIZE^2: flattened window. Element p = r*pKERNEL_SIZE+c (r, c relative to window top-left) occupies bits [(K*K-p)*W-1 -: W], so element 0 is at the MSBs.
- pixel, output, $clog2(pKERNEL_SIZE^2): element index for the consumer.
- en, output, 1: beat valid, one per element.
- frame_done, output, 1: one-cycle pulse after the last window of a frame is fully sequenced.

Behaviour:
- Reset (rst low, asynchronous):
  - in_ready=0, en=0, pixel=0, win_data=0, frame_done=0.
  - Row/column counters and state cleared to FILL.
  - Line-buffer contents don't-care.
  - First cycle after release: in_ready=1.
- States: FILL, SCAN. All outputs registered.
- FILL:
  - in_ready=1, en=0.
  - Accept occurs when in_valid & in_ready.
  - On accept at column col, row row:
    - Pixel is shifted into the line buffers and window registers.
    - col increments and wraps at pIMG_WIDTH-1 to 0, with row incrementing.
  - If row >= K-1 and col >= K-1 for the accepted pixel:
    - win_data is loaded with the window whose bottom-right is that pixel, on the same edge.
    - State -> SCAN.
  - Otherwise remain in FILL with no beats; this covers the first K-1 rows and the first K-1 columns of each later row.
- SCAN:
  - in_ready=0.
  - For exactly K*K consecutive cycles: en=1, pixel=0,1,...,K*K-1.
  - win_data is held stable for the whole scan.
  - No consumer backpressure; beats are never stalled.
  - The edge ending beat K*K-1 returns the state to FILL (en=0, in_ready=1 next cycle).
  - If that window was the frame's last (row=H-1, col=W-1):
    - frame_done=1 for the cycle following the last beat.
    - Counters reset to 0,0, ready for the next frame.
- Throughput and latency:
  - First beat (pixel=0) appears on the cycle after the accepting edge.
  - Minimum spacing between window-producing accepts is K*K+1 cycles.
- in_valid is ignored while in_ready=0; in_data is not consumed.
- Pixel index width is $clog2(K*K); no index beyond K*K-1 is ever driven.
- Window count per frame is (W-K+1)*(H-K+1).
- Reset mid-SCAN:
  - en drops immediately (asynchronous).
  - The partial window is discarded.
  - The frame restarts from pixel (0,0) after release.
- in_valid gaps in FILL cause no state change.

Test Plan:
- K=3, W=H=5, stream values 0..24 continuously with in_valid=1 -> no en during pixels 0..11. After accept of 12: en high 9 cycles, pixel 0..8. win_data elements = 0,1,2,5,6,7,10,11,12, with element 0 (value 0) at MSBs.
- Same stream -> exactly 9 scans. Windows end at pixels 12,13,14,17,18,19,22,23,24. Pixels 15,16,20,21 are accepted with in_ready continuously high and no scan. frame_done pulses once, the cycle after the pixel=8 beat of the window ending at 24.
- in_valid held high during SCAN -> in_ready=0 for 9 cycles. Source holds pixel 13 and it is accepted exactly once. Second window = 1,2,3,6,7,8,11,12,13.
- Random in_valid gaps (50%) over two back-to-back frames -> both frames produce identical window sequences to the gapless run. frame_done pulses twice.
- Assert rst low during beat pixel=4 of window 2 -> en, in_ready, frame_done go 0 asynchronously. After release, re-sending 0..24 reproduces the first-scenario window sequence exactly.
- Reset values: hold rst low, toggle in_valid -> in_ready=0, en=0, win_data=0, pixel=0 throughout.
